// File: rtl/stk_pkg.sv
// Shared types for the stack-engine command/response interface.
//   opcode_t  : host/stack command opcode
//   engid_t   : stack engine identifier
//   status_t  : stack response status
//   cmd_tag_t : per-command tag kept while a command is in flight
package stk_pkg;

  localparam int OPCODE_W = 2;
  localparam int ENGID_W  = 2;
  localparam int STATUS_W = 2;

  typedef enum logic [OPCODE_W-1:0] {
    OPCODE_NOP  = 2'd0,
    OPCODE_PUSH = 2'd1,
    OPCODE_POP  = 2'd2,
    OPCODE_INV  = 2'd3
  } opcode_t;

  typedef logic [ENGID_W-1:0] engid_t;

  typedef enum logic [STATUS_W-1:0] {
    STATUS_OKAY     = 2'd0,
    STATUS_ERRFULL  = 2'd1,
    STATUS_ERREMPTY = 2'd2,
    STATUS_RSVD     = 2'd3
  } status_t;

  typedef struct packed {
    opcode_t opcode;
    engid_t  engid;
  } cmd_tag_t;

  localparam int CMD_TAG_W = $bits(cmd_tag_t);

endpackage

// File: rtl/stk_client_tagq.sv
// In-order tag FIFO for commands in flight.
//   clk, arst_n : clock, asynchronous active-low reset
//   push, wdata : write one entry (ignored when full)
//   pop, rdata  : drop head entry (ignored when empty); rdata shows the head
//   full, empty : occupancy flags
//   count       : current occupancy, 0..Depth
// Depth must be a power of two so pointers wrap naturally.
module stk_client_tagq #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 8,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            push,
  input  logic [Width-1:0] wdata,
  input  logic            pop,
  output logic [Width-1:0] rdata,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/stk_client.sv
// Initiator side of the stack-engine interface.
//   req_*        : host request in (valid/ready)
//   cmd_*        : registered command to stack engines (valid/ready)
//   rsp_*        : in-order stack responses (no backpressure)
//   hst_*        : registered completed responses to host (single-cycle pulse)
//   err_*_cnt    : saturating ERRFULL / ERREMPTY counters
//   err_inv      : sticky, an INV request was accepted
//   err_spurious : sticky, a response arrived with nothing in flight
module stk_client
  import stk_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned INFLIGHT_N = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                clk,
  input  logic                arst_n,
  input  logic                req_vld,
  input  logic [OPCODE_W-1:0] req_opcode,
  input  logic [ENGID_W-1:0]  req_engid,
  input  logic [W-1:0]        req_dat,
  output logic                req_rdy,
  output logic                cmd_vld,
  output logic [OPCODE_W-1:0] cmd_opcode,
  output logic [ENGID_W-1:0]  cmd_engid,
  output logic [W-1:0]        cmd_dat,
  input  logic                cmd_rdy,
  input  logic                rsp_vld,
  input  logic [STATUS_W-1:0] rsp_status,
  input  logic [W-1:0]        rsp_dat,
  output logic                hst_vld,
  output logic [OPCODE_W-1:0] hst_opcode,
  output logic [ENGID_W-1:0]  hst_engid,
  output logic [STATUS_W-1:0] hst_status,
  output logic [W-1:0]        hst_dat,
  output logic [CNT_W-1:0]    err_full_cnt,
  output logic [CNT_W-1:0]    err_empty_cnt,
  output logic                err_inv,
  output logic                err_spurious
);

  localparam int unsigned OccW = $clog2(INFLIGHT_N) + 1;

  logic                 req_fire, req_fwd, cmd_fire, rsp_take;
  logic [OccW-1:0]      inflight_cnt, reserved;
  logic                 tagq_full, tagq_empty;
  logic [CMD_TAG_W-1:0] push_tag, head_raw;
  cmd_tag_t             head_tag;

  // A valid command register holds a slot that the tag queue has not seen yet.
  assign reserved = inflight_cnt + OccW'(cmd_vld);
  assign req_rdy  = (!cmd_vld || cmd_rdy) && (reserved < OccW'(INFLIGHT_N)) && !tagq_full;
  assign req_fire = req_vld && req_rdy;
  assign req_fwd  = req_fire && (req_opcode != OPCODE_INV);
  assign cmd_fire = cmd_vld && cmd_rdy;
  assign rsp_take = rsp_vld && !tagq_empty;
  assign push_tag = {cmd_opcode, cmd_engid};
  assign head_tag = cmd_tag_t'(head_raw);

  stk_client_tagq #(
    .Width (CMD_TAG_W),
    .Depth (INFLIGHT_N)
  ) u_tagq (
    .clk    (clk),
    .arst_n (arst_n),
    .push   (cmd_fire),
    .wdata  (push_tag),
    .pop    (rsp_take),
    .rdata  (head_raw),
    .full   (tagq_full),
    .empty  (tagq_empty),
    .count  (inflight_cnt)
  );

  // Command stage: req_fwd only fires when the register is free or draining.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cmd_vld    <= 1'b0;
      cmd_opcode <= '0;
      cmd_engid  <= '0;
      cmd_dat    <= '0;
    end else if (req_fwd) begin
      cmd_vld    <= 1'b1;
      cmd_opcode <= req_opcode;
      cmd_engid  <= req_engid;
      cmd_dat    <= (req_opcode == OPCODE_PUSH) ? req_dat : '0;
    end else if (cmd_fire) begin
      cmd_vld <= 1'b0;
    end
  end

  // Response stage, counters and sticky flags.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      hst_vld       <= 1'b0;
      hst_opcode    <= '0;
      hst_engid     <= '0;
      hst_status    <= '0;
      hst_dat       <= '0;
      err_full_cnt  <= '0;
      err_empty_cnt <= '0;
      err_inv       <= 1'b0;
      err_spurious  <= 1'b0;
    end else begin
      hst_vld <= rsp_take;
      if (rsp_take) begin
        hst_opcode <= head_tag.opcode;
        hst_engid  <= head_tag.engid;
        hst_status <= rsp_status;
        hst_dat    <= (head_tag.opcode == OPCODE_POP && rsp_status == STATUS_OKAY) ?
                      rsp_dat : '0;
        if (rsp_status == STATUS_ERRFULL && err_full_cnt != '1) begin
          err_full_cnt <= err_full_cnt + CNT_W'(1);
        end
        if (rsp_status == STATUS_ERREMPTY && err_empty_cnt != '1) begin
          err_empty_cnt <= err_empty_cnt + CNT_W'(1);
        end
      end
      if (req_fire && req_opcode == OPCODE_INV) err_inv <= 1'b1;
      if (rsp_vld && tagq_empty)                err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stk_client.sv
module tb_stk_client;
  import stk_pkg::*;

  localparam int unsigned W = 32;
  localparam int unsigned N = 4;
  localparam int unsigned CW = 4;

  logic                clk, arst_n;
  logic                req_vld, req_rdy, cmd_vld, cmd_rdy, rsp_vld, hst_vld;
  logic [OPCODE_W-1:0] req_opcode, cmd_opcode, hst_opcode;
  logic [ENGID_W-1:0]  req_engid, cmd_engid, hst_engid;
  logic [STATUS_W-1:0] rsp_status, hst_status;
  logic [W-1:0]        req_dat, cmd_dat, rsp_dat, hst_dat;
  logic [CW-1:0]       err_full_cnt, err_empty_cnt;
  logic                err_inv, err_spurious;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_cmd_q [$];
  logic [63:0] exp_hst_q [$];
  logic [63:0] mon_exp;

  stk_client #(.W(W), .INFLIGHT_N(N), .CNT_W(CW)) dut (
    .clk(clk), .arst_n(arst_n),
    .req_vld(req_vld), .req_opcode(req_opcode), .req_engid(req_engid), .req_dat(req_dat),
    .req_rdy(req_rdy),
    .cmd_vld(cmd_vld), .cmd_opcode(cmd_opcode), .cmd_engid(cmd_engid), .cmd_dat(cmd_dat),
    .cmd_rdy(cmd_rdy),
    .rsp_vld(rsp_vld), .rsp_status(rsp_status), .rsp_dat(rsp_dat),
    .hst_vld(hst_vld), .hst_opcode(hst_opcode), .hst_engid(hst_engid),
    .hst_status(hst_status), .hst_dat(hst_dat),
    .err_full_cnt(err_full_cnt), .err_empty_cnt(err_empty_cnt),
    .err_inv(err_inv), .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor: compares every command handshake and host response with the scoreboard.
  always @(negedge clk) begin
    if (arst_n) begin
      if (cmd_vld && cmd_rdy) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_cmd: got %0h required none",
                   64'({cmd_opcode, cmd_engid, cmd_dat}));
        end else begin
          mon_exp = exp_cmd_q.pop_front();
          check("cmd", 64'({cmd_opcode, cmd_engid, cmd_dat}), mon_exp);
        end
      end
      if (hst_vld) begin
        if (exp_hst_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_hst: got %0h required none",
                   64'({hst_opcode, hst_engid, hst_status, hst_dat}));
        end else begin
          mon_exp = exp_hst_q.pop_front();
          check("hst", 64'({hst_opcode, hst_engid, hst_status, hst_dat}), mon_exp);
        end
      end
    end
  end

  task automatic do_req(input logic [1:0] op, input logic [1:0] eng, input logic [31:0] dat);
    int n;
    @(posedge clk); #1;
    req_vld = 1'b1; req_opcode = op; req_engid = eng; req_dat = dat;
    n = 0;
    @(negedge clk);
    while (!req_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_rdy) begin
      checks++; errors++;
      $display("FAIL req_timeout: req_rdy got 0 required 1");
    end else if (op != OPCODE_INV) begin
      exp_cmd_q.push_back(64'({op, eng, dat}));
    end
    @(posedge clk); #1;
    req_vld = 1'b0;
  endtask

  task automatic do_rsp(input logic [1:0] st, input logic [31:0] dat, input logic exp_hst,
                        input logic [1:0] eop, input logic [1:0] eeng, input logic [31:0] edat);
    @(posedge clk); #1;
    rsp_vld = 1'b1; rsp_status = st; rsp_dat = dat;
    if (exp_hst) exp_hst_q.push_back(64'({eop, eeng, st, edat}));
    @(posedge clk); #1;
    rsp_vld = 1'b0;
    @(negedge clk);
    check("hst_vld_latency", 64'(hst_vld), 64'(exp_hst));
  endtask

  initial begin
    arst_n = 1'b0;
    req_vld = 1'b0; req_opcode = '0; req_engid = '0; req_dat = '0;
    cmd_rdy = 1'b1; rsp_vld = 1'b0; rsp_status = '0; rsp_dat = '0;
    #12;
    check("rst_cmd_vld", 64'(cmd_vld), 64'(0));
    check("rst_hst_vld", 64'(hst_vld), 64'(0));
    check("rst_cmd_dat", 64'(cmd_dat), 64'(0));
    check("rst_cnts", 64'({err_full_cnt, err_empty_cnt}), 64'(0));
    check("rst_flags", 64'({err_inv, err_spurious}), 64'(0));
    @(negedge clk) arst_n = 1'b1;
    @(negedge clk);
    check("rst_req_rdy", 64'(req_rdy), 64'(1));

    // PUSH then OKAY: host gets PUSH/1/OKAY with zero data.
    do_req(OPCODE_PUSH, 2'd1, 32'hA5);
    @(negedge clk);
    check("cmd_vld_cycle1", 64'(cmd_vld), 64'(1));
    do_rsp(STATUS_OKAY, 32'hDEAD, 1'b1, OPCODE_PUSH, 2'd1, 32'h0);

    // POP returns data only on OKAY.
    do_req(OPCODE_POP, 2'd2, 32'h0);
    do_rsp(STATUS_OKAY, 32'h1234, 1'b1, OPCODE_POP, 2'd2, 32'h1234);
    do_req(OPCODE_POP, 2'd3, 32'h0);
    do_rsp(STATUS_ERREMPTY, 32'h5555, 1'b1, OPCODE_POP, 2'd3, 32'h0);
    check("err_empty_1", 64'(err_empty_cnt), 64'(1));

    // Backpressure: stalled command stays stable and blocks new requests.
    cmd_rdy = 1'b0;
    do_req(OPCODE_PUSH, 2'd0, 32'h77);
    req_vld = 1'b1; req_opcode = OPCODE_POP; req_engid = 2'd1; req_dat = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_cmd_vld", 64'(cmd_vld), 64'(1));
      check("stall_cmd", 64'({cmd_opcode, cmd_engid, cmd_dat}), 64'({OPCODE_PUSH, 2'd0, 32'h77}));
      check("stall_req_rdy", 64'(req_rdy), 64'(0));
    end
    req_vld = 1'b0;
    cmd_rdy = 1'b1;
    do_req(OPCODE_POP, 2'd1, 32'h0);
    do_rsp(STATUS_OKAY, 32'h5A5A, 1'b1, OPCODE_PUSH, 2'd0, 32'h0);
    do_rsp(STATUS_OKAY, 32'hBEEF, 1'b1, OPCODE_POP, 2'd1, 32'hBEEF);

    // In-flight limit: N commands outstanding block further requests.
    do_req(OPCODE_NOP, 2'd0, 32'h0);
    do_req(OPCODE_PUSH, 2'd1, 32'h11);
    do_req(OPCODE_POP, 2'd2, 32'h0);
    do_req(OPCODE_NOP, 2'd3, 32'h0);
    req_vld = 1'b1; req_opcode = OPCODE_PUSH; req_engid = 2'd2; req_dat = 32'h22;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("limit_req_rdy", 64'(req_rdy), 64'(0));
    end
    req_vld = 1'b0;
    do_rsp(STATUS_OKAY, 32'h99, 1'b1, OPCODE_NOP, 2'd0, 32'h0);
    check("limit_release", 64'(req_rdy), 64'(1));
    do_req(OPCODE_PUSH, 2'd2, 32'h22);
    do_rsp(STATUS_ERRFULL, 32'h7, 1'b1, OPCODE_PUSH, 2'd1, 32'h0);

    // Simultaneous push and pop at occupancy N-1.
    cmd_rdy = 1'b0;
    do_req(OPCODE_POP, 2'd3, 32'h0);
    cmd_rdy = 1'b1; rsp_vld = 1'b1; rsp_status = STATUS_OKAY; rsp_dat = 32'hCAFE;
    exp_hst_q.push_back(64'({OPCODE_POP, 2'd2, STATUS_OKAY, 32'hCAFE}));
    @(posedge clk); #1;
    rsp_vld = 1'b0;
    @(negedge clk);
    check("simul_hst_vld", 64'(hst_vld), 64'(1));
    check("simul_req_rdy", 64'(req_rdy), 64'(1));
    do_rsp(STATUS_RSVD, 32'h1, 1'b1, OPCODE_NOP, 2'd3, 32'h0);
    do_rsp(STATUS_ERRFULL, 32'h2, 1'b1, OPCODE_PUSH, 2'd2, 32'h0);
    do_rsp(STATUS_ERREMPTY, 32'hFFFF, 1'b1, OPCODE_POP, 2'd3, 32'h0);
    check("err_full_2", 64'(err_full_cnt), 64'(2));
    check("err_empty_2", 64'(err_empty_cnt), 64'(2));

    // INV is swallowed; spurious response is dropped.
    check("err_inv_pre", 64'(err_inv), 64'(0));
    do_req(OPCODE_INV, 2'd1, 32'hFF);
    @(negedge clk);
    check("inv_no_cmd", 64'(cmd_vld), 64'(0));
    check("err_inv", 64'(err_inv), 64'(1));
    check("err_spur_pre", 64'(err_spurious), 64'(0));
    do_rsp(STATUS_OKAY, 32'h1, 1'b0, 2'd0, 2'd0, 32'h0);
    check("err_spurious", 64'(err_spurious), 64'(1));

    // Counter saturation.
    for (int i = 0; i < 16; i++) begin
      logic [1:0] e;
      e = 2'(i);
      do_req(OPCODE_POP, e, 32'h0);
      do_rsp(STATUS_ERRFULL, 32'h100 + 32'(i), 1'b1, OPCODE_POP, e, 32'h0);
    end
    check("err_full_sat", 64'(err_full_cnt), 64'(15));
    check("err_empty_hold", 64'(err_empty_cnt), 64'(2));

    // Reset mid-stream.
    do_req(OPCODE_PUSH, 2'd2, 32'h33);
    do_req(OPCODE_POP, 2'd1, 32'h0);
    @(posedge clk); #1;
    cmd_rdy = 1'b0;
    do_req(OPCODE_PUSH, 2'd3, 32'h44);
    @(posedge clk); #3;
    arst_n = 1'b0;
    #1;
    check("mrst_cmd", 64'({cmd_vld, cmd_opcode, cmd_engid, cmd_dat}), 64'(0));
    check("mrst_hst", 64'({hst_vld, hst_opcode, hst_engid, hst_status, hst_dat}), 64'(0));
    check("mrst_cnts", 64'({err_full_cnt, err_empty_cnt}), 64'(0));
    check("mrst_flags", 64'({err_inv, err_spurious}), 64'(0));
    exp_cmd_q.delete();
    @(negedge clk) arst_n = 1'b1;
    cmd_rdy = 1'b1;
    do_rsp(STATUS_OKAY, 32'h9, 1'b0, 2'd0, 2'd0, 32'h0);
    check("mrst_spurious", 64'(err_spurious), 64'(1));

    check("cmd_q_drained", 64'(exp_cmd_q.size()), 64'(0));
    check("hst_q_drained", 64'(exp_hst_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
